// File: rtl/ddr_sample_reader.sv
// Readback engine for packed ADC captures: issues READ bursts on MCB port p2 and
// unpacks each 32-bit word into three 10-bit samples with OR/trigger flags.
// Optional read-error checking is enabled by defining DDR_READER_ERRCHK_EN.
module ddr_sample_reader #(
    parameter int unsigned BURST_WORDS = 64,
    parameter int unsigned ADDR_STEP   = 256
) (
    input  logic        ddr_usrclk,
    input  logic        ddr_usrreset,
    input  logic        start,
    input  logic [29:0] start_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic        c3_p2_cmd_en,
    output logic [2:0]  c3_p2_cmd_instr,
    output logic [5:0]  c3_p2_cmd_bl,
    output logic [29:0] c3_p2_cmd_byte_addr,
    input  logic        c3_p2_cmd_full,
    output logic        c3_p2_rd_en,
    input  logic [31:0] c3_p2_rd_data,
    input  logic        c3_p2_rd_empty,
`ifdef DDR_READER_ERRCHK_EN
    input  logic        c3_p2_rd_overflow,
    input  logic        c3_p2_rd_error,
    output logic        rd_err,
`endif
    output logic [9:0]  sample_data,
    output logic        sample_or,
    output logic        sample_trig,
    output logic        sample_valid,
    input  logic        sample_ready
);

    localparam int unsigned CNT_W = $clog2(BURST_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_POP,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [15:0]      bursts_left_q, bursts_left_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       idx_q, idx_d;
    logic             sample_valid_q, sample_valid_d;
    logic             cmd_en_q, cmd_en_d;
    logic [29:0]      cmd_addr_q, cmd_addr_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             last_sample;
    logic             burst_more_words;
    logic             more_bursts;
    logic             abort;

`ifdef DDR_READER_ERRCHK_EN
    logic rd_err_q, rd_err_d;

    assign abort  = (state_q != S_IDLE) && (c3_p2_rd_overflow || c3_p2_rd_error);
    assign rd_err = rd_err_q;

    always_comb begin
        rd_err_d = rd_err_q;
        if (state_q == S_IDLE && start) begin
            rd_err_d = 1'b0;
        end
        if (abort) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign xfer             = sample_valid_q && sample_ready;
    assign last_sample      = xfer && (idx_q == 2'd2);
    assign burst_more_words = (word_cnt_q < CNT_W'(BURST_WORDS));
    assign more_bursts      = (bursts_left_q > 16'd1);

    assign c3_p2_cmd_instr     = 3'b001;
    assign c3_p2_cmd_bl        = 6'(BURST_WORDS - 1);
    assign c3_p2_cmd_en        = cmd_en_q;
    assign c3_p2_cmd_byte_addr = cmd_addr_q;
    assign sample_valid        = sample_valid_q;
    assign done                = done_q;

    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_bursts == '0) ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                if (!c3_p2_cmd_full) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (!c3_p2_rd_empty) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_EMIT;
            S_EMIT: begin
                if (last_sample) begin
                    if (burst_more_words) begin
                        state_d = S_POP;
                    end else if (more_bursts) begin
                        state_d = S_CMD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An error in DONE lets the engine fall back to IDLE as usual.
        if (abort) begin
            state_d = (state_q == S_DONE) ? S_IDLE : S_DONE;
        end
    end

    always_comb begin
        addr_d         = addr_q;
        bursts_left_d  = bursts_left_q;
        word_cnt_d     = word_cnt_q;
        word_d         = word_q;
        idx_d          = idx_q;
        sample_valid_d = sample_valid_q;
        cmd_en_d       = 1'b0;
        cmd_addr_d     = cmd_addr_q;
        done_d         = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start && num_bursts != '0) begin
                    addr_d        = start_addr & ~30'h0FF;
                    bursts_left_d = num_bursts;
                end
            end
            S_CMD: begin
                if (!c3_p2_cmd_full && !abort) begin
                    cmd_en_d   = 1'b1;
                    cmd_addr_d = addr_q;
                    word_cnt_d = '0;
                end
            end
            S_CAPTURE: begin
                word_d         = c3_p2_rd_data;
                idx_d          = 2'd0;
                word_cnt_d     = word_cnt_q + CNT_W'(1);
                sample_valid_d = 1'b1;
            end
            S_EMIT: begin
                if (xfer) begin
                    if (idx_q != 2'd2) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        sample_valid_d = 1'b0;
                        if (!burst_more_words && more_bursts) begin
                            addr_d        = addr_q + 30'(ADDR_STEP);
                            bursts_left_d = bursts_left_q - 16'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (abort) begin
            sample_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ddr_usrclk) begin
        if (ddr_usrreset) begin
            addr_q         <= '0;
            bursts_left_q  <= '0;
            word_cnt_q     <= '0;
            word_q         <= '0;
            idx_q          <= '0;
            sample_valid_q <= 1'b0;
            cmd_en_q       <= 1'b0;
            cmd_addr_q     <= '0;
            done_q         <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            bursts_left_q  <= bursts_left_d;
            word_cnt_q     <= word_cnt_d;
            word_q         <= word_d;
            idx_q          <= idx_d;
            sample_valid_q <= sample_valid_d;
            cmd_en_q       <= cmd_en_d;
            cmd_addr_q     <= cmd_addr_d;
            done_q         <= done_d;
        end
    end

    // Pop is combinational so the FIFO word lands in time for CAPTURE.
    always_comb begin
        busy        = (state_q != S_IDLE);
        c3_p2_rd_en = (state_q == S_POP) && !c3_p2_rd_empty && !abort;
        sample_or   = word_q[31];
        sample_trig = word_q[30];
        case (idx_q)
            2'd0:    sample_data = word_q[9:0];
            2'd1:    sample_data = word_q[19:10];
            default: sample_data = word_q[29:20];
        endcase
    end

endmodule

// File: tb/tb_ddr_sample_reader.sv
// Directed testbench for ddr_sample_reader with an on-demand MCB read FIFO model.
module tb_ddr_sample_reader;

    logic        clk = 1'b0;
    logic        ddr_usrreset;
    logic        start;
    logic [29:0] start_addr;
    logic [15:0] num_bursts;
    logic        busy, done;
    logic        c3_p2_cmd_en;
    logic [2:0]  c3_p2_cmd_instr;
    logic [5:0]  c3_p2_cmd_bl;
    logic [29:0] c3_p2_cmd_byte_addr;
    logic        c3_p2_cmd_full;
    logic        c3_p2_rd_en;
    logic [31:0] c3_p2_rd_data;
    logic        c3_p2_rd_empty;
    logic [9:0]  sample_data;
    logic        sample_or, sample_trig, sample_valid;
    logic        sample_ready;
`ifdef DDR_READER_ERRCHK_EN
    logic        c3_p2_rd_overflow, c3_p2_rd_error, rd_err;
`endif

    int n_checks, n_fail;
    int cyc;
    int pops;
    bit const_mode;

    int          cmd_t[$];
    logic [29:0] cmd_a[$];
    int          rd_t[$];
    int          done_t[$];
    logic [11:0] samp[$];
    int          samp_t[$];

    ddr_sample_reader #(.BURST_WORDS(64), .ADDR_STEP(256)) dut (
        .ddr_usrclk          (clk),
        .ddr_usrreset        (ddr_usrreset),
        .start               (start),
        .start_addr          (start_addr),
        .num_bursts          (num_bursts),
        .busy                (busy),
        .done                (done),
        .c3_p2_cmd_en        (c3_p2_cmd_en),
        .c3_p2_cmd_instr     (c3_p2_cmd_instr),
        .c3_p2_cmd_bl        (c3_p2_cmd_bl),
        .c3_p2_cmd_byte_addr (c3_p2_cmd_byte_addr),
        .c3_p2_cmd_full      (c3_p2_cmd_full),
        .c3_p2_rd_en         (c3_p2_rd_en),
        .c3_p2_rd_data       (c3_p2_rd_data),
        .c3_p2_rd_empty      (c3_p2_rd_empty),
`ifdef DDR_READER_ERRCHK_EN
        .c3_p2_rd_overflow   (c3_p2_rd_overflow),
        .c3_p2_rd_error      (c3_p2_rd_error),
        .rd_err              (rd_err),
`endif
        .sample_data         (sample_data),
        .sample_or           (sample_or),
        .sample_trig         (sample_trig),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready)
    );

    initial forever #5 clk = ~clk;

    // Word n carries samples 3n, 3n+1, 3n+2 (mod 1024), OR = n[0], trig = n[1].
    function automatic logic [31:0] gen_word(input bit cm, input int n);
        logic [31:0] nv;
        nv = n;
        if (cm) return 32'hBFFAA955;
        return {nv[0], nv[1], 10'(3 * n + 2), 10'(3 * n + 1), 10'(3 * n)};
    endfunction

    // Expected {or, trig, data} of the k-th sample of a run starting at word w0.
    function automatic logic [11:0] exp_samp(input bit cm, input int w0, input int k);
        int w, p;
        logic [31:0] wv;
        w = w0 + k / 3;
        p = k % 3;
        if (cm) begin
            if (p == 0) return {2'b10, 10'h155};
            if (p == 1) return {2'b10, 10'h2AA};
            return {2'b10, 10'h3FF};
        end
        wv = w;
        return {wv[0], wv[1], 10'(3 * w + p)};
    endfunction

    // MCB read FIFO model: data appears the cycle after an accepted pop.
    initial begin
        logic [31:0] pend;
        bit do_pop;
        pops = 0;
        c3_p2_rd_data = '0;
        forever begin
            @(negedge clk);
            do_pop = c3_p2_rd_en && !c3_p2_rd_empty;
            if (do_pop) begin
                pend = gen_word(const_mode, pops);
                pops++;
            end
            @(posedge clk);
            #1;
            if (do_pop) c3_p2_rd_data = pend;
        end
    end

    // Event recorder, sampled on the falling edge.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (c3_p2_cmd_en) begin
                cmd_t.push_back(cyc);
                cmd_a.push_back(c3_p2_cmd_byte_addr);
            end
            if (c3_p2_rd_en) rd_t.push_back(cyc);
            if (done) done_t.push_back(cyc);
            if (sample_valid && sample_ready) begin
                samp.push_back({sample_or, sample_trig, sample_data});
                samp_t.push_back(cyc);
            end
        end
    end

    task automatic pulse_start(input logic [29:0] a, input logic [15:0] nb, output int sc);
        @(posedge clk); #1;
        start_addr = a;
        num_bursts = nb;
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget, output bit to);
        int k;
        k = 0;
        while (done_t.size() <= n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        to = (done_t.size() <= n0);
        #1;
    endtask

    task automatic wait_samples(input int target, input int budget, output bit to);
        int k;
        k = 0;
        while (samp.size() < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        to = (samp.size() < target);
    endtask

    task automatic test_reset;
        ddr_usrreset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (c3_p2_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b want 0", c3_p2_cmd_en); end
        n_checks++; if (c3_p2_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", c3_p2_rd_en); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        n_checks++; if (sample_data !== 10'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", sample_data); end
        n_checks++; if ({sample_or, sample_trig} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {sample_or, sample_trig}); end
        n_checks++; if (c3_p2_cmd_instr !== 3'b001) begin n_fail++; $display("FAIL cmd_instr: got %b want 001", c3_p2_cmd_instr); end
        n_checks++; if (c3_p2_cmd_bl !== 6'd63) begin n_fail++; $display("FAIL cmd_bl: got %0d want 63", c3_p2_cmd_bl); end
        @(posedge clk); #1;
        ddr_usrreset = 1'b0;
    endtask

    task automatic test_single_burst;
        int c0, r0, s0, d0, w0, sc, v;
        bit to;
        const_mode = 1'b1;
        c0 = cmd_t.size(); r0 = rd_t.size(); s0 = samp.size(); d0 = done_t.size(); w0 = pops;
        pulse_start(30'h100, 16'd1, sc);
        wait_done(d0, 2000, to);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL single_done_timeout: no done within 2000 cycles"); end
        n_checks++; if (cmd_t.size() - c0 !== 1) begin n_fail++; $display("FAIL single_cmd_count: got %0d want 1", cmd_t.size() - c0); end
        v = (cmd_t.size() > c0) ? int'(cmd_a[c0]) : -1;
        n_checks++; if (v !== 32'h100) begin n_fail++; $display("FAIL single_cmd_addr: got %h want 100", v); end
        v = (cmd_t.size() > c0) ? cmd_t[c0] - sc : -1;
        n_checks++; if (v !== 2) begin n_fail++; $display("FAIL start_to_cmd_latency: got %0d want 2", v); end
        n_checks++; if (rd_t.size() - r0 !== 64) begin n_fail++; $display("FAIL single_rd_count: got %0d want 64", rd_t.size() - r0); end
        v = (samp.size() > s0 && rd_t.size() > r0) ? samp_t[s0] - rd_t[r0] : -1;
        n_checks++; if (v !== 2) begin n_fail++; $display("FAIL rd_to_valid_latency: got %0d want 2", v); end
        v = (samp.size() >= s0 + 192) ? samp_t[s0 + 191] - samp_t[s0] : -1;
        n_checks++; if (v !== 317) begin n_fail++; $display("FAIL throughput_span: got %0d want 317", v); end
        n_checks++; if (samp.size() - s0 !== 192) begin n_fail++; $display("FAIL single_sample_count: got %0d want 192", samp.size() - s0); end
        for (int k = 0; k < 192 && s0 + k < samp.size(); k++) begin
            n_checks++;
            if (samp[s0 + k] !== exp_samp(1'b1, w0, k)) begin
                n_fail++; $display("FAIL single_sample[%0d]: got %h want %h", k, samp[s0 + k], exp_samp(1'b1, w0, k));
            end
        end
        n_checks++; if (done_t.size() - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_t.size() - d0); end
    endtask

    task automatic test_multi_burst;
        int c0, r0, s0, d0, w0, sc, v, lo, hi;
        bit to;
        logic [29:0] exp_a [3];
        exp_a[0] = 30'h200; exp_a[1] = 30'h300; exp_a[2] = 30'h400;
        const_mode = 1'b0;
        c0 = cmd_t.size(); r0 = rd_t.size(); s0 = samp.size(); d0 = done_t.size(); w0 = pops;
        pulse_start(30'h2A5, 16'd3, sc);
        wait_done(d0, 4000, to);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL multi_done_timeout: no done within 4000 cycles"); end
        n_checks++; if (cmd_t.size() - c0 !== 3) begin n_fail++; $display("FAIL multi_cmd_count: got %0d want 3", cmd_t.size() - c0); end
        for (int i = 0; i < 3 && c0 + i < cmd_t.size(); i++) begin
            n_checks++;
            if (cmd_a[c0 + i] !== exp_a[i]) begin n_fail++; $display("FAIL multi_cmd_addr[%0d]: got %h want %h", i, cmd_a[c0 + i], exp_a[i]); end
            lo = cmd_t[c0 + i];
            hi = (c0 + i + 1 < cmd_t.size()) ? cmd_t[c0 + i + 1] : cyc + 1;
            v = 0;
            for (int j = r0; j < rd_t.size(); j++) if (rd_t[j] >= lo && rd_t[j] < hi) v++;
            n_checks++;
            if (v !== 64) begin n_fail++; $display("FAIL multi_rd_per_burst[%0d]: got %0d want 64", i, v); end
        end
        n_checks++; if (rd_t.size() - r0 !== 192) begin n_fail++; $display("FAIL multi_rd_count: got %0d want 192", rd_t.size() - r0); end
        n_checks++; if (samp.size() - s0 !== 576) begin n_fail++; $display("FAIL multi_sample_count: got %0d want 576", samp.size() - s0); end
        for (int k = 0; k < 576 && s0 + k < samp.size(); k++) begin
            n_checks++;
            if (samp[s0 + k] !== exp_samp(1'b0, w0, k)) begin
                n_fail++; $display("FAIL multi_sample[%0d]: got %h want %h", k, samp[s0 + k], exp_samp(1'b0, w0, k));
            end
        end
        n_checks++; if (done_t.size() - d0 !== 1) begin n_fail++; $display("FAIL multi_done_count: got %0d want 1", done_t.size() - d0); end
    endtask

    task automatic test_backpressure;
        int r0, r1, s0, d0, w0, sc;
        bit to;
        const_mode = 1'b0;
        r0 = rd_t.size(); s0 = samp.size(); d0 = done_t.size(); w0 = pops;
        pulse_start(30'h1000, 16'd1, sc);
        wait_samples(s0 + 49, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_reach_timeout: sample 49 not reached"); end
        sample_ready = 1'b0;
        r1 = rd_t.size();
        repeat (10) begin
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", sample_valid); end
            n_checks++;
            if ({sample_or, sample_trig, sample_data} !== exp_samp(1'b0, w0, 49)) begin
                n_fail++; $display("FAIL bp_data_stable: got %h want %h", {sample_or, sample_trig, sample_data}, exp_samp(1'b0, w0, 49));
            end
        end
        n_checks++; if (rd_t.size() !== r1) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops want 0", rd_t.size() - r1); end
        @(posedge clk); #1;
        sample_ready = 1'b1;
        wait_done(d0, 2000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_done_timeout: no done within 2000 cycles"); end
        n_checks++; if (rd_t.size() - r0 !== 64) begin n_fail++; $display("FAIL bp_rd_count: got %0d want 64", rd_t.size() - r0); end
        n_checks++; if (samp.size() - s0 !== 192) begin n_fail++; $display("FAIL bp_sample_count: got %0d want 192", samp.size() - s0); end
        for (int k = 0; k < 192 && s0 + k < samp.size(); k++) begin
            n_checks++;
            if (samp[s0 + k] !== exp_samp(1'b0, w0, k)) begin
                n_fail++; $display("FAIL bp_sample[%0d]: got %h want %h", k, samp[s0 + k], exp_samp(1'b0, w0, k));
            end
        end
    endtask

    task automatic test_stalls;
        int c0, r0, r1, s0, d0, w0, sc, rel, v;
        bit to;
        const_mode = 1'b0;
        c0 = cmd_t.size(); r0 = rd_t.size(); s0 = samp.size(); d0 = done_t.size(); w0 = pops;
        c3_p2_cmd_full = 1'b1;
        pulse_start(30'h3FFFFF00, 16'd1, sc);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (cmd_t.size() !== c0) begin n_fail++; $display("FAIL stall_cmd_while_full: got %0d cmds want 0", cmd_t.size() - c0); end
        n_checks++; if (rd_t.size() !== r0) begin n_fail++; $display("FAIL stall_rd_while_full: got %0d pops want 0", rd_t.size() - r0); end
        c3_p2_cmd_full = 1'b0;
        rel = cyc;
        wait_samples(s0 + 30, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_reach_timeout: sample 30 not reached"); end
        v = (cmd_t.size() > c0) ? cmd_t[c0] - rel : -1;
        n_checks++; if (v !== 1) begin n_fail++; $display("FAIL stall_cmd_after_release: got %0d want 1", v); end
        v = (cmd_t.size() > c0) ? int'(cmd_a[c0]) : -1;
        n_checks++; if (v !== 32'h3FFFFF00) begin n_fail++; $display("FAIL stall_cmd_addr: got %h want 3fffff00", v); end
        c3_p2_rd_empty = 1'b1;
        r1 = rd_t.size();
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (rd_t.size() !== r1) begin n_fail++; $display("FAIL stall_rd_while_empty: got %0d pops want 0", rd_t.size() - r1); end
        c3_p2_rd_empty = 1'b0;
        wait_done(d0, 2000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_done_timeout: no done within 2000 cycles"); end
        n_checks++; if (rd_t.size() - r0 !== 64) begin n_fail++; $display("FAIL stall_rd_count: got %0d want 64", rd_t.size() - r0); end
        n_checks++; if (samp.size() - s0 !== 192) begin n_fail++; $display("FAIL stall_sample_count: got %0d want 192", samp.size() - s0); end
        for (int k = 0; k < 192 && s0 + k < samp.size(); k++) begin
            n_checks++;
            if (samp[s0 + k] !== exp_samp(1'b0, w0, k)) begin
                n_fail++; $display("FAIL stall_sample[%0d]: got %h want %h", k, samp[s0 + k], exp_samp(1'b0, w0, k));
            end
        end
    endtask

    task automatic test_zero_bursts;
        int c0, d0, sc, v;
        c0 = cmd_t.size(); d0 = done_t.size();
        @(posedge clk); #1;
        num_bursts = 16'd0; start_addr = 30'h500; start = 1'b1; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_pulse: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b want 0", busy); end
        @(posedge clk); @(posedge clk); #1;
        v = (done_t.size() > d0) ? done_t[d0] - sc : -1;
        n_checks++; if (v !== 2) begin n_fail++; $display("FAIL zero_done_latency: got %0d want 2", v); end
        n_checks++; if (done_t.size() - d0 !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_t.size() - d0); end
        n_checks++; if (cmd_t.size() !== c0) begin n_fail++; $display("FAIL zero_no_cmd: got %0d cmds want 0", cmd_t.size() - c0); end
    endtask

    task automatic test_reset_mid;
        int c0, r0, s0, d0, w0, sc, v;
        bit to;
        const_mode = 1'b0;
        s0 = samp.size();
        pulse_start(30'h800, 16'd1, sc);
        wait_samples(s0 + 100, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rst_reach_timeout: sample 100 not reached"); end
        ddr_usrreset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", sample_valid); end
        n_checks++; if ({sample_or, sample_trig, sample_data} !== 12'h000) begin n_fail++; $display("FAIL rst_mid_sample: got %h want 000", {sample_or, sample_trig, sample_data}); end
        n_checks++; if ({c3_p2_cmd_en, c3_p2_rd_en, done} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_strobes: got %b want 000", {c3_p2_cmd_en, c3_p2_rd_en, done}); end
        @(posedge clk); #1;
        ddr_usrreset = 1'b0;
        c0 = cmd_t.size(); r0 = rd_t.size(); s0 = samp.size(); d0 = done_t.size(); w0 = pops;
        pulse_start(30'h9C0, 16'd1, sc);
        wait_done(d0, 2000, to);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL rst_restart_timeout: no done within 2000 cycles"); end
        v = (cmd_t.size() > c0) ? int'(cmd_a[c0]) : -1;
        n_checks++; if (v !== 32'h900) begin n_fail++; $display("FAIL rst_restart_addr: got %h want 900", v); end
        n_checks++; if (rd_t.size() - r0 !== 64) begin n_fail++; $display("FAIL rst_restart_rd_count: got %0d want 64", rd_t.size() - r0); end
        n_checks++; if (samp.size() - s0 !== 192) begin n_fail++; $display("FAIL rst_restart_samples: got %0d want 192", samp.size() - s0); end
        for (int k = 0; k < 192 && s0 + k < samp.size(); k++) begin
            n_checks++;
            if (samp[s0 + k] !== exp_samp(1'b0, w0, k)) begin
                n_fail++; $display("FAIL rst_restart_sample[%0d]: got %h want %h", k, samp[s0 + k], exp_samp(1'b0, w0, k));
            end
        end
        n_checks++; if (done_t.size() - d0 !== 1) begin n_fail++; $display("FAIL rst_restart_done_count: got %0d want 1", done_t.size() - d0); end
    endtask

`ifdef DDR_READER_ERRCHK_EN
    task automatic test_error;
        int d0, w0, sc, k;
        bit to;
        const_mode = 1'b0;
        d0 = done_t.size(); w0 = pops;
        pulse_start(30'h0, 16'd2, sc);
        k = 0;
        while (pops - w0 < 10 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++; if (k >= 1000) begin n_fail++; $display("FAIL err_reach_timeout: word 10 not reached"); end
        c3_p2_rd_error = 1'b1;
        @(posedge clk); #1;
        c3_p2_rd_error = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", rd_err); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL err_valid_drop: got %b want 0", sample_valid); end
        wait_done(d0, 10, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL err_done_timeout: no done after error"); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", rd_err); end
        n_checks++; if (done_t.size() - d0 !== 1) begin n_fail++; $display("FAIL err_done_count: got %0d want 1", done_t.size() - d0); end
        pulse_start(30'h0, 16'd0, sc);
        @(negedge clk);
        n_checks++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b want 0", rd_err); end
        repeat (3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        const_mode = 1'b0;
        ddr_usrreset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        num_bursts = '0;
        c3_p2_cmd_full = 1'b0;
        c3_p2_rd_empty = 1'b0;
        sample_ready = 1'b1;
`ifdef DDR_READER_ERRCHK_EN
        c3_p2_rd_overflow = 1'b0;
        c3_p2_rd_error = 1'b0;
`endif
        test_reset;
        test_single_burst;
        test_multi_burst;
        test_backpressure;
        test_stalls;
        test_zero_bursts;
        test_reset_mid;
`ifdef DDR_READER_ERRCHK_EN
        test_error;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_sample_reader.md
# ddr_sample_reader

Readback engine for ADC captures stored in LPDDR. It issues 64-word READ bursts on MCB port p2 and pops the returned 32-bit words. Each word is unpacked into its three 10-bit ADC samples plus overrange/trigger flags, which are streamed out over a valid/ready interface. It is the inverse of the capture path's packing: word[31]=OR, word[30]=trig, [29:20]=sample2, [19:10]=sample1, [9:0]=sample0. It sits between the MCB user interface and the USB/host readout logic, in the `ddr_usrclk` domain.

## Interface
Parameters:
- `BURST_WORDS`, 64: 32-bit words per READ command. `c3_p2_cmd_bl` = `BURST_WORDS-1`.
- `ADDR_STEP`, 256: byte-address increment between bursts (`BURST_WORDS*4`).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `ddr_usrclk` in 1: MCB user clock; all logic is on its rising edge.
  - `ddr_usrreset` in 1: synchronous, active-high reset.
- Control:
  - `start` in 1: one-cycle request; sampled only in IDLE.
  - `start_addr` in 30: byte address of the first burst. Bits [7:0] are forced to 0.
  - `num_bursts` in 16: number of bursts to read.
  - `busy` out 1: high in any state other than IDLE.
  - `done` out 1: one-cycle pulse at end of readback.
- MCB port p2 command:
  - `c3_p2_cmd_en` out 1.
  - `c3_p2_cmd_instr` out 3: constant 3'b001.
  - `c3_p2_cmd_bl` out 6.
  - `c3_p2_cmd_byte_addr` out 30.
  - `c3_p2_cmd_full` in 1.
- MCB port p2 read data:
  - `c3_p2_rd_en` out 1.
  - `c3_p2_rd_data` in 32: valid the cycle after an `rd_en` issued while `rd_empty` is 0.
  - `c3_p2_rd_empty` in 1.
- Sample stream:
  - `sample_data` out 10.
  - `sample_or` out 1.
  - `sample_trig` out 1.
  - `sample_valid` out 1.
  - `sample_ready` in 1.

## Operation
- States: IDLE, CMD, POP, CAPTURE, EMIT, DONE.
- IDLE:
  - On `start` with `num_bursts`==0, go to DONE.
  - On `start` otherwise, load `addr`=`{start_addr[29:8],8'h00}` and `bursts_left`=`num_bursts`, then go to CMD.
  - `start` arriving in any other state is ignored.
- CMD:
  - While `c3_p2_cmd_full`=1, wait; `cmd_en` stays 0.
  - Otherwise assert `cmd_en` for exactly one cycle with `byte_addr`=`addr`, clear `word_cnt`, and go to POP.
- POP:
  - While `rd_empty`=1, wait.
  - Otherwise assert `rd_en` for exactly one cycle and go to CAPTURE.
  - At most one pop per word.
- CAPTURE:
  - `word_reg` <= `c3_p2_rd_data`; `idx` <= 0; `word_cnt` <= `word_cnt`+1; `sample_valid` <= 1.
  - Go to EMIT.
- EMIT: outputs are driven from `word_reg` and `idx`.
  - `sample_data` = `word_reg[10*idx+9 : 10*idx]`.
  - `sample_or` = `word_reg[31]`; `sample_trig` = `word_reg[30]`. Both flags are identical for all three samples of a word.
  - Transfer occurs when `sample_valid` & `sample_ready`.
  - On transfer with `idx`<2: `idx` increments.
  - On transfer with `idx`==2: `sample_valid` <= 0, then:
    - `word_cnt` < `BURST_WORDS`: go to POP.
    - `word_cnt` == `BURST_WORDS` and `bursts_left`>1: `addr` += `ADDR_STEP`, `bursts_left` decrements, go to CMD.
    - Otherwise: go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is 30-bit and wraps modulo 2^30 without error.
- Handshake: while `sample_valid`=1 and `sample_ready`=0, `sample_data`, `sample_or` and `sample_trig` hold stable. `sample_valid` never drops without a transfer.

## Timing
- Reset values, applied the cycle after `ddr_usrreset` is sampled high:
  - State IDLE.
  - `busy`, `done`, `cmd_en`, `rd_en`, `sample_valid` = 0.
  - `sample_data`=0, `sample_or`=0, `sample_trig`=0.
  - `addr`=0, `idx`=0, `word_cnt`=0.
  - `c3_p2_cmd_instr` and `c3_p2_cmd_bl` are constants, unaffected by reset.
- Reset mid-operation abandons the burst. Words left in the MCB read FIFO are the system's responsibility; the MCB is also reset by `ddr_usrreset`.
- Latency:
  - `start` to `cmd_en`: 2 cycles when `cmd_full`=0.
  - `rd_en` to `sample_valid` high: 2 cycles.
- Throughput with `sample_ready` tied high and `rd_empty`=0: 3 samples per 5 cycles.
- `num_bursts`=0: `done` is asserted 2 cycles after `start`; no `cmd_en` is issued.
- Exactly `BURST_WORDS` `rd_en` pulses are issued per `cmd_en`.

## Configuration
- `DDR_READER_ERRCHK_EN` defined:
  - Adds input ports `c3_p2_rd_overflow` and `c3_p2_rd_error`, and output port `rd_err`.
  - `rd_err` is sticky and is cleared only by reset or by a new accepted `start`.
  - Either error input high in any non-IDLE state sets `rd_err`, drops `sample_valid`, and forces DONE on the next cycle.
- `DDR_READER_ERRCHK_EN` undefined: these ports and this logic are absent, and the error inputs are never sampled.

## Test plan
- Single burst: `start_addr`=0x100, `num_bursts`=1, every word 0xBFFAA955 -> one `cmd_en` with `addr` 0x100 and `bl`=63. Stream is 192 samples in the repeating order 0x155, 0x2AA, 0x3FF, each with `or`=1 and `trig`=0. One `done` pulse.
- Multi-burst: `start_addr`=0x2A5, `num_bursts`=3 -> `cmd_en` at 0x200, 0x300, 0x400. 576 samples, 192 `rd_en` pulses, `done` once.
- Backpressure: `sample_ready` low for 10 cycles mid-word -> outputs stable, no extra `rd_en`, 64 pops per burst total.
- Stalls: `cmd_full` high for 20 cycles, then `rd_empty` high for 15 cycles -> no `cmd_en` or `rd_en` while asserted; the data stream is unaltered.
- Edge cases:
  - `num_bursts`=0 -> `done` 2 cycles after `start`, `busy` briefly high, no `cmd_en`.
  - Reset asserted at sample 100 -> all outputs at reset values next cycle; a subsequent `start` works normally.
- With `DDR_READER_ERRCHK_EN`: pulse `c3_p2_rd_error` at word 10 -> `rd_err`=1, `sample_valid`=0, `done` pulse; `rd_err` is held until the next `start`.
